// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage downstream of pre-IF. Holds the
//                accepted PC until the matching inst_sram response arrives,
//                forwards the instruction to decode with zero added latency,
//                and buffers one instruction under decode back-pressure.
//                Responses whose owner was flushed are counted and dropped.
//                Optional macro FS_ADEF_EN enables the fetch-address-error
//                flag for misaligned PCs.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter int PFS_BUS_W = 32,
  parameter int FS_BUS_W  = 65,
  parameter int CNCL_W    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pfs_to_fs_valid,
  input  logic [PFS_BUS_W-1:0] pfs_to_fs_bus,
  output logic                 fs_allowin,
  output logic                 fs_block,
  input  logic                 inst_sram_data_ok,
  input  logic [31:0]          inst_sram_rdata,
  input  logic                 ds_allowin,
  output logic                 fs_to_ds_valid,
  output logic [FS_BUS_W-1:0]  fs_to_ds_bus,
  input  logic                 flush,
  input  logic                 br_taken_cancel
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_READY = 2'd2;

  localparam logic [CNCL_W-1:0] c_CNT_MAX = '1;

  logic [1:0]           r_state;
  logic [PFS_BUS_W-1:0] r_pc;
  logic [31:0]          r_inst_buf;
  logic [CNCL_W-1:0]    r_cncl_cnt;

  logic        w_fs_valid;
  logic        w_kill;
  logic        w_live_ok;
  logic        w_fs_ready_go;
  logic        w_accept;
  logic        w_cnt_inc;
  logic        w_cnt_dec;
  logic        w_adef;
  logic [31:0] w_inst_raw;
  logic [31:0] w_inst;

  assign w_fs_valid    = (r_state != c_EMPTY);
  assign w_kill        = flush | br_taken_cancel;
  // A response only belongs to the held PC once every orphaned one has drained.
  assign w_live_ok     = inst_sram_data_ok && (r_cncl_cnt == '0);
  assign w_fs_ready_go = (r_state == c_READY) | ((r_state == c_WAIT) && w_live_ok);

  assign fs_allowin     = !w_fs_valid | (w_fs_ready_go && ds_allowin);
  assign fs_block       = w_fs_valid && !fs_allowin;
  assign fs_to_ds_valid = w_fs_valid && w_fs_ready_go && !w_kill;

  assign w_accept = pfs_to_fs_valid && fs_allowin;

  // Flush while still waiting leaves a response in flight with no owner.
  assign w_cnt_inc = flush && (r_state == c_WAIT) && !w_live_ok;
  assign w_cnt_dec = inst_sram_data_ok && (r_cncl_cnt != '0);

`ifdef FS_ADEF_EN
  assign w_adef = (r_pc[1:0] != 2'b00);
`else
  assign w_adef = 1'b0;
`endif

  // READY replays the buffered word; otherwise the SRAM data is bypassed.
  assign w_inst_raw = (r_state == c_READY) ? r_inst_buf : inst_sram_rdata;
  assign w_inst     = w_adef ? 32'h0 : w_inst_raw;

  assign fs_to_ds_bus = {w_adef, w_inst, r_pc};

  // Stage state, PC and back-pressure buffer; a new accept overrides every
  // other event because pre-IF has already redirected.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= c_EMPTY;
      r_pc       <= '0;
      r_inst_buf <= '0;
    end else if (w_accept) begin
      r_state <= c_WAIT;
      r_pc    <= pfs_to_fs_bus;
    end else if (w_kill) begin
      r_state <= c_EMPTY;
    end else if ((r_state == c_WAIT) && w_live_ok && !ds_allowin) begin
      r_state    <= c_READY;
      r_inst_buf <= inst_sram_rdata;
    end else if (fs_to_ds_valid && ds_allowin) begin
      r_state <= c_EMPTY;
    end
  end

  // Orphaned-response counter; simultaneous inc/dec cancel, and it holds at max.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cncl_cnt <= '0;
    end else if (w_cnt_inc && !w_cnt_dec) begin
      if (r_cncl_cnt != c_CNT_MAX) begin
        r_cncl_cnt <= r_cncl_cnt + 1'b1;
      end
    end else if (w_cnt_dec && !w_cnt_inc) begin
      r_cncl_cnt <= r_cncl_cnt - 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Reaching the counter ceiling means more orphans than it can track.
  a_cncl_not_max : assert property (@(posedge clk) disable iff (!resetn)
                                    r_cncl_cnt != c_CNT_MAX);
`endif

endmodule
`default_nettype wire
